tcm_boot_loader: RTL and testbench
==================================

# tcm_boot_loader

Loads a program image into the core's TCM from a byte stream and holds the RISC-V core in reset until the image is in place. It sits upstream of the TCM write port and the core reset input. It replaces back-door memory preloading with a synthesizable path that a host, UART or debug bridge can drive. The stream is a 4-byte little-endian word count followed by the payload, also little-endian; the block assembles 32-bit words and writes them to consecutive TCM word addresses starting at 0.

## Interface
- MEM_WORDS, 131072: TCM depth in 32-bit words; largest legal image size.
- ADDR_W, 17: word-address width; must satisfy 2^ADDR_W >= MEM_WORDS.
- clk in 1: single clock.
- rst in 1: reset, asynchronous, active-high.
- start_i in 1: one-cycle pulse that begins a load; ignored unless in IDLE, DONE or ERROR.
- byte_valid_i in 1: stream byte valid.
- byte_data_i in 8: stream byte.
- byte_ready_o out 1: byte accepted on a cycle where byte_valid_i && byte_ready_o.
- mem_wr_o out 1: TCM write request.
- mem_addr_o out ADDR_W: TCM word address.
- mem_data_o out 32: TCM write data.
- mem_accept_i in 1: TCM accepts the write on a cycle where mem_wr_o && mem_accept_i.
- core_rst_o out 1: core reset, active-high.
- busy_o out 1: load in progress.
- done_o out 1: image loaded; core released.
- error_o out 1: header rejected.

## Operation
- FSM states: IDLE, LEN, DATA, WRITE, FILL, DONE, ERROR.
- IDLE: core_rst_o=1. On start_i, go to LEN and clear the byte counter, word counter and address.
- LEN: accepts 4 bytes into len[31:0], LSB first.
  - After the 4th byte: len > MEM_WORDS goes to ERROR.
  - len == 0 goes to FILL if TCM_LOADER_ZERO_FILL_EN is defined, else DONE.
  - Otherwise go to DATA.
- DATA: accepts 4 bytes into a word shift register; byte k goes to bits [8k+7:8k]. After the 4th byte, go to WRITE.
- WRITE: mem_wr_o=1 with mem_addr_o = word counter. Address and data stay stable until mem_accept_i.
  - On accept, the word counter increments.
  - If counter+1 == len: go to FILL (macro defined and len < MEM_WORDS) or DONE.
  - Otherwise return to DATA.
- FILL: writes 32'h0 to every address from len to MEM_WORDS-1 with the same accept rule, then goes to DONE.
- DONE: core_rst_o=0, done_o=1. Stays there until start_i or rst. start_i re-asserts core_rst_o the next cycle and re-enters LEN.
- ERROR: error_o=1, core_rst_o=1, byte_ready_o=0. Only start_i or rst leaves this state.
- byte_ready_o=1 only in LEN and DATA. No byte is consumed in WRITE, FILL, DONE, ERROR or IDLE.
- Bytes beyond the declared length are not consumed; byte_ready_o stays low.

## Timing
- Reset values: core_rst_o=1; all other outputs 0; mem_addr_o=0; mem_data_o=0; state IDLE.
- start_i at cycle t: LEN is active and byte_ready_o=1 at t+1.
- 4th data byte accepted at cycle t: mem_wr_o=1 at t+1. With mem_accept_i tied high, the sustained rate is 1 word per 5 cycles.
- Last write accepted at t: done_o=1 and core_rst_o=0 at t+1, all registered.
- Asserting rst mid-load aborts immediately: the FSM returns to IDLE and core_rst_o=1. Partial TCM contents are undefined.
- start_i while busy is ignored.
- The address counter never wraps. The length check guarantees mem_addr_o <= MEM_WORDS-1.

## Configuration
- TCM_LOADER_ZERO_FILL_EN defined: after the payload, the block zero-fills TCM up to MEM_WORDS-1 before releasing the core. Release latency grows by (MEM_WORDS-len) accepted writes.
- Not defined: the FILL state is compiled out, the core is released immediately after the last payload word, and contents above the image are untouched.

## Structure
- Shared package tcm_loader_pkg holds:
  - the state enum typedef;
  - localparam HDR_BYTES=4;
  - localparam WORD_BYTES=4.
- One natural sub-module, tcm_byte_packer: the byte-to-word shift register plus the 2-bit byte counter with word_valid/word_ack. It is reused for both the header and the payload.

## Test plan
- Header len=2; bytes 78 56 34 12 EF BE AD DE; mem_accept_i=1. Expected writes: [0]=0x12345678, [1]=0xDEADBEEF. done_o=1 and core_rst_o=0 one cycle after the 2nd accept.
- Same image with mem_accept_i low for 3 cycles per write. Expected: mem_wr_o, mem_addr_o and mem_data_o held stable; byte_ready_o=0 throughout the stall; no byte lost.
- len=0x00020001 (MEM_WORDS+1). Expected: error_o=1 after the 4th header byte, no mem_wr_o ever, core_rst_o=1. A following start_i with a valid header loads correctly.
- len=0 with the macro defined and MEM_WORDS overridden to 8. Expected: 8 writes of 0 to addresses 0..7, then done_o. Without the macro: done_o one cycle after the 4th header byte and no writes.
- rst asserted after the 2nd payload byte of a 4-word image. Expected: all outputs return to reset values asynchronously. A new start_i plus a full stream completes normally.
- start_i pulsed during DATA. Expected: ignored; the load completes with the correct word count.

Source files
------------

// File: rtl/tcm_loader_pkg.sv
// tcm_loader_pkg
// Types and constants shared by the TCM boot loader and its byte packer.
//   state_t    : loader FSM states
//   HDR_BYTES  : bytes in the little-endian length header
//   WORD_BYTES : bytes per TCM word
package tcm_loader_pkg;

  localparam int unsigned HDR_BYTES  = 4;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
    FILL,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/tcm_byte_packer.sv
// tcm_byte_packer
// Collects stream bytes into a little-endian 32-bit word (byte k lands in
// bits [8k+7:8k]). Used for both the length header and every payload word.
// Ports:
//   clk, rst     : clock, async active-high reset
//   clear        : synchronous clear of byte counter, word and word_valid
//   byte_en      : a byte is being accepted this cycle
//   byte_data    : the byte being accepted
//   word_ack     : consumer has taken the assembled word
//   word         : assembled word register
//   word_next    : value word takes if byte_en is high (full word on the
//                  last byte, so the consumer can act in the same cycle)
//   last_byte    : the byte accepted this cycle completes a word
//   word_valid   : a completed word is waiting for word_ack
module tcm_byte_packer
  import tcm_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  input  logic        word_ack,
  output logic [31:0] word,
  output logic [31:0] word_next,
  output logic        last_byte,
  output logic        word_valid
);

  localparam int CNT_W = $clog2(WORD_BYTES);

  logic [CNT_W-1:0] byte_cnt_q;
  logic [31:0]      word_q;
  logic             word_valid_q;

  // New byte enters at the top and older bytes shift down, so after four
  // bytes the first one received sits in bits [7:0].
  assign word_next  = {byte_data, word_q[31:8]};
  assign last_byte  = byte_en && (byte_cnt_q == CNT_W'(WORD_BYTES - 1));
  assign word       = word_q;
  assign word_valid = word_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q   <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else if (clear) begin
      byte_cnt_q   <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      if (byte_en) begin
        word_q     <= word_next;
        byte_cnt_q <= byte_cnt_q + CNT_W'(1);
      end
      // An ack in the completing cycle means the word was consumed directly.
      if (last_byte) begin
        word_valid_q <= ~word_ack;
      end else if (word_ack) begin
        word_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tcm_boot_loader.sv
// tcm_boot_loader
// Loads a program image into TCM from a byte stream and holds the core in
// reset until the image is in place. Stream: 4-byte little-endian word
// count, then the payload words, little-endian. Words are written to TCM
// word addresses 0, 1, 2, ...
// Optional feature macro: TCM_LOADER_ZERO_FILL_EN -- when defined, TCM is
// zero-filled from len up to MEM_WORDS-1 before the core is released.
// Ports:
//   clk, rst                  : clock, async active-high reset
//   start_i                   : pulse to begin a load (IDLE/DONE/ERROR only)
//   byte_valid_i/byte_data_i  : stream byte in
//   byte_ready_o              : byte taken when valid && ready
//   mem_wr_o/addr/data        : TCM write request, held until mem_accept_i
//   mem_accept_i              : TCM takes the write
//   core_rst_o                : core reset, released only in DONE
//   busy_o/done_o/error_o     : status
//
// state | meaning
// IDLE  | after reset, core held, waiting for start_i
// LEN   | receiving the 4 header bytes
// DATA  | receiving the 4 bytes of a payload word
// WRITE | presenting a payload word to TCM
// FILL  | writing zeros above the image (zero-fill builds only)
// DONE  | image loaded, core released
// ERROR | header length exceeded MEM_WORDS, core held
module tcm_boot_loader
  import tcm_loader_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 131072,
  parameter int unsigned ADDR_W    = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              mem_wr_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  input  logic              mem_accept_i,
  output logic              core_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o
);

  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);
`ifdef TCM_LOADER_ZERO_FILL_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_WORDS - 1);
`endif

  state_t            state_q, state_d;
  logic [31:0]       len_q, len_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [31:0]       cnt_inc;

  logic        byte_fire;
  logic        pack_clear;
  logic        word_ack;
  logic [31:0] pack_word;
  logic [31:0] pack_word_next;
  logic        pack_last;
  logic        pack_valid;

  assign byte_fire = byte_valid_i && byte_ready_o;
  assign cnt_inc   = 32'(cnt_q) + 32'd1;

  tcm_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pack_clear),
    .byte_en    (byte_fire),
    .byte_data  (byte_data_i),
    .word_ack   (word_ack),
    .word       (pack_word),
    .word_next  (pack_word_next),
    .last_byte  (pack_last),
    .word_valid (pack_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    pack_clear = 1'b0;
    word_ack   = 1'b0;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start_i) begin
          state_d    = LEN;
          len_d      = '0;
          cnt_d      = '0;
          pack_clear = 1'b1;
        end
      end
      LEN: begin
        // The header never reaches the write port; consume it on completion.
        word_ack = 1'b1;
        if (pack_last) begin
          len_d = pack_word_next;
          if (pack_word_next > MEM_WORDS_W) begin
            state_d = ERROR;
          end else if (pack_word_next == '0) begin
`ifdef TCM_LOADER_ZERO_FILL_EN
            state_d = FILL;
`else
            state_d = DONE;
`endif
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (pack_last) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (mem_accept_i) begin
          word_ack = 1'b1;
          // The counter only advances when another write follows, so the
          // address never steps past MEM_WORDS-1.
          if (cnt_inc == len_q) begin
`ifdef TCM_LOADER_ZERO_FILL_EN
            if (len_q < MEM_WORDS_W) begin
              state_d = FILL;
              cnt_d   = cnt_q + ADDR_W'(1);
            end else begin
              state_d = DONE;
            end
`else
            state_d = DONE;
`endif
          end else begin
            state_d = DATA;
            cnt_d   = cnt_q + ADDR_W'(1);
          end
        end
      end
`ifdef TCM_LOADER_ZERO_FILL_EN
      FILL: begin
        if (mem_accept_i) begin
          if (cnt_q == LAST_ADDR) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign byte_ready_o = ((state_q == LEN) || (state_q == DATA)) && !pack_valid;
  assign mem_wr_o     = (state_q == WRITE) || (state_q == FILL);
  assign mem_addr_o   = cnt_q;
  assign mem_data_o   = (state_q == WRITE) ? pack_word : 32'h0;
  assign core_rst_o   = (state_q != DONE);
  assign busy_o       = (state_q == LEN) || (state_q == DATA) ||
                        (state_q == WRITE) || (state_q == FILL);
  assign done_o       = (state_q == DONE);
  assign error_o      = (state_q == ERROR);

endmodule

// File: tb/tb_tcm_boot_loader.sv
module tb_tcm_boot_loader;

`ifdef TCM_LOADER_ZERO_FILL_EN
  localparam int MEM_WORDS = 8;
  localparam int ADDR_W    = 3;
  localparam bit ZF        = 1'b1;
  localparam int RAND_MAX  = 8;
`else
  localparam int MEM_WORDS = 131072;
  localparam int ADDR_W    = 17;
  localparam bit ZF        = 1'b0;
  localparam int RAND_MAX  = 6;
`endif
  localparam int MAX_CYC = 3000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_i = 1'b0;
  logic              byte_valid_i = 1'b0;
  logic [7:0]        byte_data_i = 8'h0;
  logic              mem_accept_i = 1'b0;
  logic              byte_ready_o;
  logic              mem_wr_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_data_o;
  logic              core_rst_o;
  logic              busy_o;
  logic              done_o;
  logic              error_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  img[$];
  logic [63:0] obs_wr[$];
  logic [63:0] exp_wr[$];
  int consumed, exp_consumed, it_done, it_last_acc, it_hdr, exp_it;
  bit timed_out, exp_error, start_busy, any_wr;

  tcm_boot_loader #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .mem_wr_o     (mem_wr_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_accept_i (mem_accept_i),
    .core_rst_o   (core_rst_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o)
  );

  always #5 clk = ~clk;

  // ---------------- stimulus helpers ----------------
  task automatic apply_reset();
    rst = 1'b1; start_i = 1'b0; byte_valid_i = 1'b0; mem_accept_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_start();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic make_image(input longint len_field, input int nwords, input int extra);
    img.delete();
    for (int k = 0; k < 4; k++) img.push_back(8'((len_field >> (8 * k)) & 255));
    for (int k = 0; k < 4 * nwords + extra; k++) img.push_back(8'($urandom_range(0, 255)));
  endtask

  // Reference: what the TCM should receive for the current image.
  task automatic model();
    longint len;
    longint w;
    len = longint'(img[0]) + longint'(img[1]) * 256 + longint'(img[2]) * 65536 +
          longint'(img[3]) * 16777216;
    exp_wr.delete();
    if (len > MEM_WORDS) begin
      exp_error = 1'b1;
      exp_consumed = 4;
    end else begin
      exp_error = 1'b0;
      exp_consumed = 4 + 4 * int'(len);
      for (int i = 0; i < int'(len); i++) begin
        w = longint'(img[4 + 4*i]) + longint'(img[5 + 4*i]) * 256 +
            longint'(img[6 + 4*i]) * 65536 + longint'(img[7 + 4*i]) * 16777216;
        exp_wr.push_back({32'(i), 32'(w)});
      end
      if (ZF) for (int a = int'(len); a < MEM_WORDS; a++) exp_wr.push_back({32'(a), 32'h0});
    end
  endtask

  // Drives img into the DUT, one decision per negedge, until done/error,
  // stop_after bytes consumed, or the cycle budget runs out.
  task automatic run_load(input int gap_pct, input int stall, input int start_at,
                          input int stop_after);
    int idx, wait_cnt, this_stall, it;
    bit prev_wr, start_sent;
    logic [ADDR_W-1:0] prev_addr;
    logic [31:0] prev_data;
    idx = 0; wait_cnt = 0; prev_wr = 0; start_sent = 0; any_wr = 0;
    prev_addr = '0; prev_data = '0;
    obs_wr.delete();
    it_done = -1; it_last_acc = -1; it_hdr = -1; start_busy = 0;
    this_stall = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
    for (it = 0; it < MAX_CYC; it++) begin
      if (done_o || error_o || (stop_after >= 0 && idx >= stop_after)) begin
        it_done = it;
        break;
      end
      if (prev_wr) begin
        n_cmp++;
        if (mem_wr_o !== 1'b1 || mem_addr_o !== prev_addr || mem_data_o !== prev_data) begin
          n_err++;
          $display("FAIL stall_hold: got wr=%0b addr=%0h data=%h, want wr=1 addr=%0h data=%h",
                   mem_wr_o, mem_addr_o, mem_data_o, prev_addr, prev_data);
        end
      end
      if (mem_wr_o) begin
        any_wr = 1'b1;
        n_cmp++;
        if (byte_ready_o !== 1'b0) begin
          n_err++;
          $display("FAIL ready_in_write: got byte_ready=%0b, want 0", byte_ready_o);
        end
        mem_accept_i = (wait_cnt >= this_stall);
        wait_cnt++;
      end else begin
        mem_accept_i = 1'($urandom_range(0, 1));
      end
      start_i = 1'b0;
      if (start_at >= 0 && !start_sent && idx >= start_at) begin
        start_i = 1'b1;
        start_sent = 1'b1;
        start_busy = busy_o;
      end
      byte_valid_i = (idx < img.size()) && (int'($urandom_range(0, 99)) >= gap_pct);
      byte_data_i  = byte_valid_i ? img[idx] : 8'($urandom_range(0, 255));
      if (mem_wr_o && mem_accept_i) begin
        obs_wr.push_back({32'(mem_addr_o), mem_data_o});
        it_last_acc = it;
        wait_cnt = 0;
        prev_wr = 1'b0;
        this_stall = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
      end else begin
        prev_wr = mem_wr_o;
        prev_addr = mem_addr_o;
        prev_data = mem_data_o;
      end
      if (byte_valid_i && byte_ready_o) begin
        idx++;
        if (idx == 4) it_hdr = it;
      end
      @(negedge clk);
    end
    timed_out = (it_done < 0);
    consumed = idx;
    byte_valid_i = 1'b0;
    start_i = 1'b0;
    mem_accept_i = 1'b0;
    exp_it = (exp_wr.size() == 0) ? it_hdr + 1 : it_last_acc + 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if ({core_rst_o, busy_o, done_o, error_o, byte_ready_o, mem_wr_o} !== 6'b100000) begin
      n_err++;
      $display("FAIL reset_flags: got rst/busy/done/err/rdy/wr=%b, want 100000",
               {core_rst_o, busy_o, done_o, error_o, byte_ready_o, mem_wr_o});
    end
    n_cmp++;
    if (mem_addr_o !== '0 || mem_data_o !== 32'h0) begin
      n_err++;
      $display("FAIL reset_bus: got addr=%0h data=%h, want 0/0", mem_addr_o, mem_data_o);
    end
  endtask

  task automatic test_basic();
    img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
            8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h11, 8'h22};
    model();
    do_start();
    n_cmp++;
    if (busy_o !== 1'b1 || byte_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL basic_len_entry: got busy=%0b ready=%0b, want 1/1", busy_o, byte_ready_o);
    end
    run_load(0, 0, -1, -1);
    n_cmp++;
    if (timed_out) begin n_err++; $display("FAIL basic_timeout: got no done, want done"); end
    n_cmp++;
    if (obs_wr.size() != exp_wr.size()) begin
      n_err++;
      $display("FAIL basic_count: got %0d writes, want %0d", obs_wr.size(), exp_wr.size());
    end else begin
      foreach (exp_wr[i]) begin
        n_cmp++;
        if (obs_wr[i] !== exp_wr[i]) begin
          n_err++;
          $display("FAIL basic_write[%0d]: got %h, want %h", i, obs_wr[i], exp_wr[i]);
        end
      end
    end
    n_cmp++;
    if (obs_wr.size() < 2 || obs_wr[0][31:0] !== 32'h12345678 || obs_wr[1][31:0] !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL basic_words: got %0d writes (first two %h %h), want 12345678 deadbeef",
               obs_wr.size(), (obs_wr.size() > 0) ? obs_wr[0][31:0] : 32'h0,
               (obs_wr.size() > 1) ? obs_wr[1][31:0] : 32'h0);
    end
    n_cmp++;
    if (done_o !== 1'b1 || core_rst_o !== 1'b0 || it_done != exp_it) begin
      n_err++;
      $display("FAIL basic_release: got done=%0b core_rst=%0b at cycle %0d, want 1/0 at %0d",
               done_o, core_rst_o, it_done, exp_it);
    end
    n_cmp++;
    if (consumed != exp_consumed || byte_ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL basic_consumed: got %0d bytes ready=%0b, want %0d ready=0",
               consumed, byte_ready_o, exp_consumed);
    end
  endtask

  task automatic test_stall();
    img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
            8'hEF, 8'hBE, 8'hAD, 8'hDE};
    model();
    do_start();
    run_load(20, 3, -1, -1);
    n_cmp++;
    if (timed_out) begin n_err++; $display("FAIL stall_timeout: got no done, want done"); end
    n_cmp++;
    if (obs_wr.size() != exp_wr.size()) begin
      n_err++;
      $display("FAIL stall_count: got %0d writes, want %0d", obs_wr.size(), exp_wr.size());
    end else begin
      foreach (exp_wr[i]) begin
        n_cmp++;
        if (obs_wr[i] !== exp_wr[i]) begin
          n_err++;
          $display("FAIL stall_write[%0d]: got %h, want %h", i, obs_wr[i], exp_wr[i]);
        end
      end
    end
    n_cmp++;
    if (done_o !== 1'b1 || it_done != exp_it || consumed != exp_consumed) begin
      n_err++;
      $display("FAIL stall_release: got done=%0b cyc=%0d bytes=%0d, want 1 cyc=%0d bytes=%0d",
               done_o, it_done, consumed, exp_it, exp_consumed);
    end
  endtask

  task automatic test_error();
    make_image(longint'(MEM_WORDS) + 1, 2, 0);
    model();
    do_start();
    run_load(10, 0, -1, -1);
    n_cmp++;
    if (error_o !== 1'b1 || core_rst_o !== 1'b1 || byte_ready_o !== 1'b0 || it_done != exp_it) begin
      n_err++;
      $display("FAIL err_flag: got err=%0b core_rst=%0b rdy=%0b cyc=%0d, want 1/1/0 cyc=%0d",
               error_o, core_rst_o, byte_ready_o, it_done, exp_it);
    end
    n_cmp++;
    if (any_wr || consumed != exp_consumed) begin
      n_err++;
      $display("FAIL err_nowrite: got wr_seen=%0b bytes=%0d, want 0 bytes=%0d",
               any_wr, consumed, exp_consumed);
    end
    byte_valid_i = 1'b1;
    repeat (4) @(negedge clk);
    byte_valid_i = 1'b0;
    n_cmp++;
    if (error_o !== 1'b1 || mem_wr_o !== 1'b0 || byte_ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL err_sticky: got err=%0b wr=%0b rdy=%0b, want 1/0/0", error_o, mem_wr_o, byte_ready_o);
    end
    make_image(3, 3, 2);
    model();
    do_start();
    run_load(25, -1, -1, -1);
    n_cmp++;
    if (obs_wr != exp_wr || done_o !== 1'b1 || error_o !== 1'b0) begin
      n_err++;
      $display("FAIL err_recover: got %0d writes done=%0b err=%0b, want %0d writes done=1 err=0",
               obs_wr.size(), done_o, error_o, exp_wr.size());
    end
  endtask

  task automatic test_len_boundary();
    make_image(longint'(MEM_WORDS), 0, 4);
    do_start();
    run_load(0, 0, -1, 4);
    n_cmp++;
    if (error_o !== 1'b0 || busy_o !== 1'b1 || byte_ready_o !== 1'b1 || any_wr) begin
      n_err++;
      $display("FAIL len_max: got err=%0b busy=%0b rdy=%0b wr_seen=%0b, want 0/1/1/0",
               error_o, busy_o, byte_ready_o, any_wr);
    end
    apply_reset();
  endtask

  task automatic test_zero_len();
    make_image(0, 0, 4);
    model();
    do_start();
    run_load(0, -1, -1, -1);
    n_cmp++;
    if (timed_out || done_o !== 1'b1 || it_done != exp_it) begin
      n_err++;
      $display("FAIL zero_done: got done=%0b cyc=%0d, want 1 cyc=%0d", done_o, it_done, exp_it);
    end
    n_cmp++;
    if (obs_wr != exp_wr) begin
      n_err++;
      $display("FAIL zero_writes: got %0d writes, want %0d", obs_wr.size(), exp_wr.size());
    end
    n_cmp++;
    if (consumed != 4) begin
      n_err++;
      $display("FAIL zero_consumed: got %0d bytes, want 4", consumed);
    end
  endtask

  task automatic test_rst_abort();
    make_image(4, 4, 0);
    do_start();
    run_load(0, 0, -1, 6);
    n_cmp++;
    if (busy_o !== 1'b1 || core_rst_o !== 1'b1) begin
      n_err++;
      $display("FAIL abort_pre: got busy=%0b core_rst=%0b, want 1/1", busy_o, core_rst_o);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({core_rst_o, busy_o, done_o, error_o, byte_ready_o, mem_wr_o} !== 6'b100000 ||
        mem_addr_o !== '0 || mem_data_o !== 32'h0) begin
      n_err++;
      $display("FAIL abort_async: got flags=%b addr=%0h data=%h, want 100000/0/0",
               {core_rst_o, busy_o, done_o, error_o, byte_ready_o, mem_wr_o}, mem_addr_o, mem_data_o);
    end
    @(negedge clk);
    rst = 1'b0;
    make_image(4, 4, 1);
    model();
    do_start();
    run_load(15, -1, -1, -1);
    n_cmp++;
    if (obs_wr != exp_wr || done_o !== 1'b1 || consumed != exp_consumed) begin
      n_err++;
      $display("FAIL abort_reload: got %0d writes done=%0b bytes=%0d, want %0d writes done=1 bytes=%0d",
               obs_wr.size(), done_o, consumed, exp_wr.size(), exp_consumed);
    end
  endtask

  task automatic test_start_in_data();
    make_image(3, 3, 3);
    model();
    do_start();
    run_load(10, 1, 6, -1);
    n_cmp++;
    if (start_busy !== 1'b1) begin
      n_err++;
      $display("FAIL busy_start_sent: got busy=%0b when start pulsed, want 1", start_busy);
    end
    n_cmp++;
    if (obs_wr != exp_wr || done_o !== 1'b1 || consumed != exp_consumed) begin
      n_err++;
      $display("FAIL busy_start_load: got %0d writes done=%0b bytes=%0d, want %0d writes done=1 bytes=%0d",
               obs_wr.size(), done_o, consumed, exp_wr.size(), exp_consumed);
    end
  endtask

  task automatic test_back_to_back();
    int nw;
    for (int r = 0; r < 8; r++) begin
      nw = int'($urandom_range(1, RAND_MAX));
      make_image(longint'(nw), nw, int'($urandom_range(0, 3)));
      model();
      do_start();
      n_cmp++;
      if (core_rst_o !== 1'b1 || done_o !== 1'b0 || byte_ready_o !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_restart[%0d]: got core_rst=%0b done=%0b rdy=%0b, want 1/0/1",
                 r, core_rst_o, done_o, byte_ready_o);
      end
      run_load(30, -1, -1, -1);
      n_cmp++;
      if (timed_out || done_o !== 1'b1 || it_done != exp_it || consumed != exp_consumed) begin
        n_err++;
        $display("FAIL b2b_done[%0d]: got done=%0b cyc=%0d bytes=%0d, want 1 cyc=%0d bytes=%0d",
                 r, done_o, it_done, consumed, exp_it, exp_consumed);
      end
      n_cmp++;
      if (obs_wr.size() != exp_wr.size()) begin
        n_err++;
        $display("FAIL b2b_count[%0d]: got %0d writes, want %0d", r, obs_wr.size(), exp_wr.size());
      end else begin
        foreach (exp_wr[i]) begin
          n_cmp++;
          if (obs_wr[i] !== exp_wr[i]) begin
            n_err++;
            $display("FAIL b2b_write[%0d][%0d]: got %h, want %h", r, i, obs_wr[i], exp_wr[i]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_error();
    test_len_boundary();
    test_zero_len();
    test_rst_abort();
    test_start_in_data();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
